// File: rtl/iic_eeprom_slave_if.sv
// Bus-side signals of the 24C02-style I2C EEPROM target: sampled scl plus the write-commit and busy indications.
// sda stays a plain inout on the target because it is an open-drain wire.
interface iic_eeprom_slave_if #(
  parameter int MEM_AW = 8
);
  logic              scl;
  logic              busy;
  logic              wr_stb;
  logic [MEM_AW-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output scl,
    input  busy,
    input  wr_stb,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  scl,
    output busy,
    output wr_stb,
    output wr_addr,
    output wr_data
  );
endinterface

// File: rtl/iic_eeprom_slave.sv
// I2C target emulating a 24C02 EEPROM (byte/page write, current/random/sequential read) on an oversampled scl/sda pair.
// Optional write protect: define IIC_SLV_WP_EN to add the 'wp' input.
module iic_eeprom_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h53,
  parameter int         MEM_AW   = 8
) (
  input  logic CLOCK_50,
  input  logic rst,
`ifdef IIC_SLV_WP_EN
  input  logic wp,
`endif
  inout  wire  sda,
  iic_eeprom_slave_if.slave bus
);

  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_DEVADDR   = 4'd1,
    S_DEVACK    = 4'd2,
    S_WADDR     = 4'd3,
    S_WADDR_ACK = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        scl_pipe_q, scl_pipe_d;
  logic [2:0]        sda_pipe_q, sda_pipe_d;
  logic [7:0]        shift_q, shift_d;
  logic [3:0]        bitcnt_q, bitcnt_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic              rw_q, rw_d;
  logic              sda_oe_q, sda_oe_d;
  logic              busy_q, busy_d;
  logic              wr_stb_q, wr_stb_d;
  logic [MEM_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        mem_q [DEPTH];

  logic       scl_rise_s, scl_fall_s, start_s, stop_s, sda_bit_s;
  logic       ack_slot_s, addr_hit_s, wr_allow_s, mem_we_s;
  logic [7:0] byte_s, rd_byte_s;

  // Pipe index 1 is the synchronised level, index 2 is its one-clock history.
  assign scl_rise_s = scl_pipe_q[1] & ~scl_pipe_q[2];
  assign scl_fall_s = ~scl_pipe_q[1] & scl_pipe_q[2];
  assign start_s    = scl_pipe_q[1] & scl_pipe_q[2] & sda_pipe_q[2] & ~sda_pipe_q[1];
  assign stop_s     = scl_pipe_q[1] & scl_pipe_q[2] & ~sda_pipe_q[2] & sda_pipe_q[1];
  assign sda_bit_s  = sda_pipe_q[1];
  assign byte_s     = {shift_q[6:0], sda_bit_s};
  assign ack_slot_s = scl_fall_s & (bitcnt_q == 4'd8);
  assign addr_hit_s = (byte_s[7:1] == DEV_ADDR);
  assign rd_byte_s  = mem_q[ptr_q];

`ifdef IIC_SLV_WP_EN
  assign wr_allow_s = ~wp;
`else
  assign wr_allow_s = 1'b1;
`endif

  assign sda         = sda_oe_q ? 1'b0 : 1'bz;
  assign bus.busy    = busy_q;
  assign bus.wr_stb  = wr_stb_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;

  assign scl_pipe_d = {scl_pipe_q[1:0], bus.scl};
  assign sda_pipe_d = {sda_pipe_q[1:0], sda};

  // State and datapath registers.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q    <= S_IDLE;
      scl_pipe_q <= 3'b111;
      sda_pipe_q <= 3'b111;
      shift_q    <= 8'h00;
      bitcnt_q   <= 4'd0;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      scl_pipe_q <= scl_pipe_d;
      sda_pipe_q <= sda_pipe_d;
      shift_q    <= shift_d;
      bitcnt_q   <= bitcnt_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Byte array; the write lands on the same edge that raises wr_stb.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (mem_we_s) begin
      mem_q[ptr_q] <= byte_s;
    end
  end

  // Next-state logic; START/STOP override whatever the bit engine is doing.
  always_comb begin
    state_d = state_q;
    if (start_s) begin
      state_d = S_DEVADDR;
    end else if (stop_s) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_DEVADDR: begin
          if (scl_rise_s && (bitcnt_q == 4'd7) && !addr_hit_s) begin
            state_d = S_IDLE;
          end else if (ack_slot_s) begin
            state_d = S_DEVACK;
          end else begin
            state_d = S_DEVADDR;
          end
        end
        S_DEVACK: begin
          if (scl_fall_s) begin
            state_d = rw_q ? S_RDATA : S_WADDR;
          end else begin
            state_d = S_DEVACK;
          end
        end
        S_WADDR:     state_d = ack_slot_s ? S_WADDR_ACK : S_WADDR;
        S_WADDR_ACK: state_d = scl_fall_s ? S_WDATA : S_WADDR_ACK;
        S_WDATA:     state_d = ack_slot_s ? S_WDATA_ACK : S_WDATA;
        S_WDATA_ACK: state_d = scl_fall_s ? S_WDATA : S_WDATA_ACK;
        S_RDATA:     state_d = ack_slot_s ? S_RDATA_ACK : S_RDATA;
        S_RDATA_ACK: begin
          if (scl_rise_s && sda_bit_s) begin
            state_d = S_IDLE;
          end else if (scl_fall_s && (bitcnt_q == 4'd1)) begin
            state_d = S_RDATA;
          end else begin
            state_d = S_RDATA_ACK;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output and datapath logic: shifting, ACK drive, pointer, commit.
  always_comb begin
    shift_d   = shift_q;
    bitcnt_d  = bitcnt_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    wr_stb_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    mem_we_s  = 1'b0;
    if (start_s) begin
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
    end else if (stop_s) begin
      bitcnt_d = 4'd0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
        S_DEVADDR, S_WADDR, S_WDATA: begin
          if (scl_rise_s) begin
            shift_d  = byte_s;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd7) begin
              case (state_q)
                S_DEVADDR: begin
                  busy_d = addr_hit_s;
                  rw_d   = byte_s[0];
                end
                S_WADDR: ptr_d = byte_s[MEM_AW-1:0];
                S_WDATA: begin
                  // Write-protected bytes are still ACKed and still advance the pointer.
                  ptr_d     = ptr_q + MEM_AW'(1);
                  mem_we_s  = wr_allow_s;
                  wr_stb_d  = wr_allow_s;
                  wr_addr_d = wr_allow_s ? ptr_q : wr_addr_q;
                  wr_data_d = wr_allow_s ? byte_s : wr_data_q;
                end
                default: ptr_d = ptr_q;
              endcase
            end else begin
              ptr_d = ptr_q;
            end
          end else if (ack_slot_s) begin
            sda_oe_d = 1'b1;
            bitcnt_d = 4'd0;
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        S_DEVACK: begin
          if (scl_fall_s) begin
            bitcnt_d = 4'd0;
            if (rw_q) begin
              shift_d  = rd_byte_s;
              sda_oe_d = ~rd_byte_s[7];
            end else begin
              sda_oe_d = 1'b0;
            end
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        S_WADDR_ACK, S_WDATA_ACK: begin
          if (scl_fall_s) begin
            sda_oe_d = 1'b0;
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        S_RDATA: begin
          if (scl_rise_s) begin
            bitcnt_d = bitcnt_q + 4'd1;
          end else if (ack_slot_s) begin
            sda_oe_d = 1'b0;
            bitcnt_d = 4'd0;
          end else if (scl_fall_s) begin
            shift_d  = {shift_q[6:0], 1'b0};
            sda_oe_d = ~shift_q[6];
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        S_RDATA_ACK: begin
          // bitcnt==1 marks a master ACK; the next byte goes out at the following scl fall.
          if (scl_rise_s) begin
            ptr_d = ptr_q + MEM_AW'(1);
            if (!sda_bit_s) begin
              bitcnt_d = 4'd1;
            end else begin
              busy_d = 1'b0;
            end
          end else if (scl_fall_s && (bitcnt_q == 4'd1)) begin
            shift_d  = rd_byte_s;
            sda_oe_d = ~rd_byte_s[7];
            bitcnt_d = 4'd0;
          end else begin
            sda_oe_d = sda_oe_q;
          end
        end
        default: begin
          sda_oe_d = 1'b0;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iic_eeprom_slave.sv
// Directed bench for iic_eeprom_slave: bit-banged I2C master with a pull-up on sda and a wr_stb monitor.
module tb_iic_eeprom_slave;
  localparam int Q = 10;

  logic clk = 1'b0;
  logic rst;
  logic m_sda_low;
  wire  sda;
`ifdef IIC_SLV_WP_EN
  logic wp;
`endif

  int checks = 0;
  int failures = 0;
  int stb_count = 0;
  logic [7:0] stb_addr = 8'h00;
  logic [7:0] stb_data = 8'h00;

  iic_eeprom_slave_if #(.MEM_AW(8)) bus ();

  pullup pu_sda (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  always #10 clk = ~clk;

  iic_eeprom_slave #(.DEV_ADDR(7'h53), .MEM_AW(8)) dut (
    .CLOCK_50 (clk),
    .rst      (rst),
`ifdef IIC_SLV_WP_EN
    .wp       (wp),
`endif
    .sda      (sda),
    .bus      (bus)
  );

  always @(negedge clk) begin
    if (bus.wr_stb === 1'b1) begin
      stb_count = stb_count + 1;
      stb_addr  = bus.wr_addr;
      stb_data  = bus.wr_data;
    end
  end

  task automatic qwait();
    repeat (Q) @(posedge clk);
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; qwait();
    bus.scl = 1'b1;   qwait();
    m_sda_low = 1'b1; qwait();
    bus.scl = 1'b0;   qwait();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; qwait();
    bus.scl = 1'b1;   qwait();
    m_sda_low = 1'b0; qwait();
  endtask

  task automatic send_bit(input logic b);
    m_sda_low = ~b; qwait();
    bus.scl = 1'b1; qwait(); qwait();
    bus.scl = 1'b0; qwait();
  endtask

  task automatic recv_bit(output logic b);
    m_sda_low = 1'b0; qwait();
    bus.scl = 1'b1;   qwait();
    b = sda;          qwait();
    bus.scl = 1'b0;   qwait();
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack);
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.scl = 1'b1; m_sda_low = 1'b0;
`ifdef IIC_SLV_WP_EN
    wp = 1'b0;
`endif
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.wr_stb !== 1'b0) begin failures++; $display("FAIL reset_wr_stb got=%b exp=0", bus.wr_stb); end
    checks++; if (bus.wr_addr !== 8'h00) begin failures++; $display("FAIL reset_wr_addr got=%h exp=00", bus.wr_addr); end
    checks++; if (bus.wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr_data got=%h exp=00", bus.wr_data); end
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL reset_sda got=%b exp=1", sda); end
    rst = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_byte_write();
    logic ack;
    int n0;
    n0 = stb_count;
    i2c_start();
    send_byte(8'hA6, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL t1_dev_ack got=%b exp=0", ack); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL t1_busy got=%b exp=1", bus.busy); end
    send_byte(8'h32, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL t1_addr_ack got=%b exp=0", ack); end
    send_byte(8'hD2, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL t1_data_ack got=%b exp=0", ack); end
    i2c_stop();
    repeat (5) @(negedge clk);
    checks++; if (stb_count !== n0 + 1) begin failures++; $display("FAIL t1_stb_count got=%0d exp=%0d", stb_count, n0 + 1); end
    checks++; if (stb_addr !== 8'h32) begin failures++; $display("FAIL t1_wr_addr got=%h exp=32", stb_addr); end
    checks++; if (stb_data !== 8'hD2) begin failures++; $display("FAIL t1_wr_data got=%h exp=d2", stb_data); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL t1_busy_after_stop got=%b exp=0", bus.busy); end
  endtask

  task automatic test_random_read(input string tag, input logic [7:0] addr, input logic [7:0] exp);
    logic ack;
    logic [7:0] d;
    i2c_start();
    send_byte(8'hA6, ack);
    send_byte(addr, ack);
    i2c_start();
    send_byte(8'hA7, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL %s_rd_ack got=%b exp=0", tag, ack); end
    recv_byte(1'b1, d);
    checks++; if (d !== exp) begin failures++; $display("FAIL %s_rd_data got=%h exp=%h", tag, d, exp); end
    i2c_stop();
    repeat (5) @(negedge clk);
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL %s_sda_released got=%b exp=1", tag, sda); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL %s_busy_idle got=%b exp=0", tag, bus.busy); end
  endtask

  task automatic test_addr_mismatch();
    logic ack;
    int n0;
    n0 = stb_count;
    i2c_start();
    send_byte(8'hA0, ack);
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL t3_no_ack got=%b exp=1", ack); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL t3_busy got=%b exp=0", bus.busy); end
    send_byte(8'h55, ack);
    i2c_stop();
    repeat (5) @(negedge clk);
    checks++; if (stb_count !== n0) begin failures++; $display("FAIL t3_stb_count got=%0d exp=%0d", stb_count, n0); end
    test_random_read("t3", 8'h32, 8'hD2);
  endtask

  task automatic test_page_wrap();
    logic ack;
    logic [7:0] d;
    int n0;
    n0 = stb_count;
    i2c_start();
    send_byte(8'hA6, ack);
    send_byte(8'hFF, ack);
    send_byte(8'h11, ack);
    send_byte(8'h22, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL t4_wrap_ack got=%b exp=0", ack); end
    i2c_stop();
    repeat (5) @(negedge clk);
    checks++; if (stb_count !== n0 + 2) begin failures++; $display("FAIL t4_stb_count got=%0d exp=%0d", stb_count, n0 + 2); end
    checks++; if (stb_addr !== 8'h00) begin failures++; $display("FAIL t4_wrap_addr got=%h exp=00", stb_addr); end
    i2c_start();
    send_byte(8'hA6, ack);
    send_byte(8'hFF, ack);
    i2c_start();
    send_byte(8'hA7, ack);
    recv_byte(1'b0, d);
    checks++; if (d !== 8'h11) begin failures++; $display("FAIL t4_seq_byte0 got=%h exp=11", d); end
    recv_byte(1'b1, d);
    checks++; if (d !== 8'h22) begin failures++; $display("FAIL t4_seq_byte1 got=%h exp=22", d); end
    i2c_stop();
    repeat (5) @(negedge clk);
  endtask

  task automatic test_partial_stop();
    logic ack;
    int n0;
    n0 = stb_count;
    i2c_start();
    send_byte(8'hA6, ack);
    send_byte(8'h10, ack);
    for (int i = 0; i < 5; i++) send_bit(i[0] ? 1'b0 : 1'b1);
    i2c_stop();
    repeat (5) @(negedge clk);
    checks++; if (stb_count !== n0) begin failures++; $display("FAIL t5_stb_count got=%0d exp=%0d", stb_count, n0); end
    test_random_read("t5", 8'h10, 8'h00);
  endtask

  task automatic test_current_read();
    logic ack;
    logic [7:0] d;
    i2c_start();
    send_byte(8'hA6, ack);
    send_byte(8'h50, ack);
    send_byte(8'h77, ack);
    send_byte(8'h88, ack);
    i2c_stop();
    i2c_start();
    send_byte(8'hA6, ack);
    send_byte(8'h50, ack);
    send_byte(8'h99, ack);
    i2c_stop();
    i2c_start();
    send_byte(8'hA7, ack);
    recv_byte(1'b1, d);
    checks++; if (d !== 8'h88) begin failures++; $display("FAIL cur_read got=%h exp=88", d); end
    i2c_stop();
    repeat (5) @(negedge clk);
  endtask

`ifdef IIC_SLV_WP_EN
  task automatic test_write_protect();
    logic ack;
    int n0;
    n0 = stb_count;
    wp = 1'b1;
    i2c_start();
    send_byte(8'hA6, ack);
    send_byte(8'h32, ack);
    send_byte(8'h55, ack);
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL wp_data_ack got=%b exp=0", ack); end
    i2c_stop();
    repeat (5) @(negedge clk);
    wp = 1'b0;
    checks++; if (stb_count !== n0) begin failures++; $display("FAIL wp_stb_count got=%0d exp=%0d", stb_count, n0); end
    test_random_read("wp", 8'h32, 8'hD2);
  endtask
`endif

  task automatic test_reset_mid_read();
    logic ack;
    i2c_start();
    send_byte(8'hA6, ack);
    send_byte(8'h00, ack);
    i2c_start();
    send_byte(8'hA7, ack);
    @(negedge clk);
    checks++; if (sda !== 1'b0) begin failures++; $display("FAIL t6_sda_driven got=%b exp=0", sda); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (sda !== 1'b1) begin failures++; $display("FAIL t6_sda_release got=%b exp=1", sda); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL t6_busy got=%b exp=0", bus.busy); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    i2c_stop();
    test_random_read("t6", 8'h32, 8'h00);
  endtask

  initial begin
    rst = 1'b1;
    m_sda_low = 1'b0;
    bus.scl = 1'b1;
    test_reset();
    test_byte_write();
    test_random_read("t2", 8'h32, 8'hD2);
    test_addr_mismatch();
    test_page_wrap();
    test_partial_stop();
    test_current_read();
`ifdef IIC_SLV_WP_EN
    test_write_protect();
`endif
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
